// File: rtl/backscatter_window_modulator_pkg.sv
// Shared types and reset constants for the backscatter window modulator.
// Optional data modulation is enabled with BACKSCATTER_DATA_MOD_EN.
package backscatter_mod_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        ACTIVE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Window waveform selection.
    localparam logic MODE_CONST  = 1'b0;
    localparam logic MODE_SQUARE = 1'b1;

    // Reset values for the parameters and runtime config registers.
    localparam int DEF_CNT_W        = 16;
    localparam int DEF_DELAY_CYCLES = 5080;
    localparam int DEF_LEN_CYCLES   = 54921;
    localparam int DEF_HALF_CYCLES  = 1;
    localparam int DEF_BIT_CYCLES   = 64;

endpackage

// File: rtl/backscatter_window_modulator_wave_gen.sv
// Window waveform generator: square-wave phase with a half-period counter,
// restarted on each window start. With BACKSCATTER_DATA_MOD_EN defined it
// also consumes one data bit per BIT_CYCLES slot and inverts the slot on a 1.
// wave_next is the value the top registers onto output_signal on this edge.
module mod_wave_gen
    import backscatter_mod_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
`ifdef BACKSCATTER_DATA_MOD_EN
    ,
    parameter int BIT_CYCLES = DEF_BIT_CYCLES
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             advance,
    input  logic             mode,
    input  logic [CNT_W-1:0] half,
`ifdef BACKSCATTER_DATA_MOD_EN
    input  logic             idle,
    input  logic             data_bit,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             underrun,
`endif
    output logic             wave_next
);

    logic             phase;
    logic [CNT_W-1:0] hcnt;
    logic             mode_q;
    logic [CNT_W-1:0] half_eff;
    logic             toggle;
    logic             phase_next;
    logic             base_next;

    // A zero half-period behaves like a half-period of one cycle.
    assign half_eff   = (half == '0) ? CNT_W'(1) : half;
    assign toggle     = (hcnt == half_eff - CNT_W'(1));
    assign phase_next = toggle ? ~phase : phase;
    // Every window opens high; square mode then follows the phase.
    assign base_next  = start ? 1'b1 : ((mode_q == MODE_SQUARE) ? phase_next : 1'b1);

    // Phase and half-period counter, mode latched at window start.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase  <= 1'b0;
            hcnt   <= '0;
            mode_q <= MODE_CONST;
        end else if (start) begin
            phase  <= 1'b1;
            hcnt   <= '0;
            mode_q <= mode;
        end else if (advance) begin
            phase <= phase_next;
            hcnt  <= toggle ? '0 : hcnt + CNT_W'(1);
        end
    end

`ifdef BACKSCATTER_DATA_MOD_EN
    localparam int SW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    logic [SW-1:0] scnt;
    logic          inv;
    logic          slot_start;
    logic          inv_next;

    // A slot begins at the window start and every BIT_CYCLES cycles after.
    assign slot_start = start || (advance && (scnt == SW'(BIT_CYCLES - 1)));
    assign inv_next   = slot_start ? (data_valid & data_bit) : inv;
    assign data_ready = slot_start;
    assign wave_next  = base_next ^ inv_next;

    // Slot position, held slot bit and sticky underrun flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scnt     <= '0;
            inv      <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (start) begin
                scnt <= '0;
            end else if (advance) begin
                scnt <= (scnt == SW'(BIT_CYCLES - 1)) ? '0 : scnt + SW'(1);
            end
            if (start || advance) begin
                inv <= inv_next;
            end
            // A missing bit at slot start wins over the idle clear so a
            // zero-delay window entered from IDLE still reports it.
            if (slot_start && !data_valid) begin
                underrun <= 1'b1;
            end else if (idle) begin
                underrun <= 1'b0;
            end
        end
    end
`else
    assign wave_next = base_next;
`endif

endmodule

// File: rtl/backscatter_window_modulator.sv
// Trigger-gated window modulator: after a programmable delay it drives a
// constant-high or square-wave window of programmable length.
// Config handshake: a config is taken on an edge with cfg_valid && cfg_ready;
// cfg_ready is only high in IDLE with the trigger low, so the source holds
// cfg_valid until then. BACKSCATTER_DATA_MOD_EN adds per-slot data inversion.
module backscatter_window_modulator
    import backscatter_mod_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int DEF_DELAY  = DEF_DELAY_CYCLES,
    parameter int DEF_LEN    = DEF_LEN_CYCLES,
    parameter int DEF_HALF   = DEF_HALF_CYCLES,
    parameter int BIT_CYCLES = DEF_BIT_CYCLES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             trigger_signal,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_len,
    input  logic             cfg_mode,
    input  logic [CNT_W-1:0] cfg_half,
`ifdef BACKSCATTER_DATA_MOD_EN
    input  logic             data_bit,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             underrun,
`endif
    output logic             output_signal,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] delay_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] half_q;
    logic             mode_q;
    logic             delay_hit;
    logic             delay_over;
    logic             window_last;
    logic             win_start;
    logic             win_advance;
    logic             wave_next;
    logic [CNT_W-1:0] count_inc;

    assign count_inc   = (count == '1) ? count : count + CNT_W'(1);
    assign delay_hit   = (state == DELAY) && (count == delay_q - CNT_W'(1));
    assign delay_over  = ((state == IDLE) && (delay_q == '0)) || delay_hit;
    assign window_last = (state == ACTIVE) && (count == len_q - CNT_W'(1));
    assign win_start   = trigger_signal && delay_over && (len_q != '0);
    assign win_advance = trigger_signal && (state == ACTIVE) && !window_last;
    assign cfg_ready   = (state == IDLE) && !trigger_signal;
    assign busy        = (state != IDLE);

    // Runtime config registers, all four loaded together on a handshake.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            delay_q <= CNT_W'(DEF_DELAY);
            len_q   <= CNT_W'(DEF_LEN);
            half_q  <= CNT_W'(DEF_HALF);
            mode_q  <= MODE_CONST;
        end else if (cfg_valid && cfg_ready) begin
            delay_q <= cfg_delay;
            len_q   <= cfg_len;
            half_q  <= cfg_half;
            mode_q  <= cfg_mode;
        end
    end

    // Window sequencer with registered drive and done pulse; trigger low aborts.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            count         <= '0;
            output_signal <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!trigger_signal) begin
                state         <= IDLE;
                count         <= '0;
                output_signal <= 1'b0;
            end else begin
                case (state)
                    IDLE, DELAY: begin
                        if (delay_over) begin
                            count <= '0;
                            if (len_q == '0) begin
                                // Empty window: straight to DONE, silent.
                                state         <= DONE;
                                output_signal <= 1'b0;
                            end else begin
                                state         <= ACTIVE;
                                output_signal <= wave_next;
                            end
                        end else if (state == IDLE) begin
                            state <= DELAY;
                            count <= '0;
                        end else begin
                            count <= count_inc;
                        end
                    end
                    ACTIVE: begin
                        if (window_last) begin
                            state         <= DONE;
                            count         <= '0;
                            output_signal <= 1'b0;
                            done          <= 1'b1;
                        end else begin
                            count         <= count_inc;
                            output_signal <= wave_next;
                        end
                    end
                    DONE: begin
                        output_signal <= 1'b0;
                    end
                    default: begin
                        state         <= IDLE;
                        output_signal <= 1'b0;
                    end
                endcase
            end
        end
    end

    mod_wave_gen #(
        .CNT_W      (CNT_W)
`ifdef BACKSCATTER_DATA_MOD_EN
        ,
        .BIT_CYCLES (BIT_CYCLES)
`endif
    ) u_wave (
        .clock      (clock),
        .reset      (reset),
        .start      (win_start),
        .advance    (win_advance),
        .mode       (mode_q),
        .half       (half_q),
`ifdef BACKSCATTER_DATA_MOD_EN
        .idle       (state == IDLE),
        .data_bit   (data_bit),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .underrun   (underrun),
`endif
        .wave_next  (wave_next)
    );

endmodule
